// File: rtl/io_arb_pkg.sv
// ---------------------------------------------------------------------------
// io_arb_pkg
// Shared definitions for the IO pad bank arbiter:
//   - io_arb_state_t : arbiter FSM states (IDLE, OWN, DRAIN)
//   - DEF_*          : default values for the arbiter parameters
// Optional feature macro used by the top: IO_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package io_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } io_arb_state_t;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_W           = 16;
  localparam int DEF_TURN_CYCLES = 2;
  localparam int DEF_TIMEOUT     = 1024;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Scans req_i starting at ptr_i and
// wrapping around; the first set bit wins.
// Ports:
//   req_i     in  N_REQ : request vector
//   ptr_i     in  IW    : highest-priority index
//   valid_o   out 1     : any request present
//   win_oh_o  out N_REQ : one-hot winner
//   win_idx_o out IW    : binary winner index
// ---------------------------------------------------------------------------
module rr_picker
  import io_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic             valid_o,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [IW-1:0]    win_idx_o
);

  int w_idx;

  always_comb begin
    valid_o   = 1'b0;
    win_oh_o  = '0;
    win_idx_o = '0;
    w_idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = (int'(ptr_i) + i) % N_REQ;
      if (!valid_o && req_i[w_idx]) begin
        valid_o          = 1'b1;
        win_oh_o[w_idx]  = 1'b1;
        win_idx_o        = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/io_pad_arbiter.sv
// ---------------------------------------------------------------------------
// io_pad_arbiter
// Grants one of N_REQ requesters exclusive ownership of a W-bit pad bank.
// The owner's output/enable slice is registered onto the pads; after
// ownership ends the pads are held all-input for TURN_CYCLES cycles before
// the next grant so two drivers never overlap on the board.
//
// Optional feature: define IO_ARB_TIMEOUT_EN to bound ownership to TIMEOUT
// cycles whenever another requester is waiting.
//
// Ports:
//   wb_clk_i    in  1        : clock, rising edge
//   wb_rst_i    in  1        : synchronous active-high reset
//   req_i       in  N_REQ    : per-requester request level
//   req_out_i   in  N_REQ*W  : per-requester pad outputs, slice k=[k*W +: W]
//   req_oeb_i   in  N_REQ*W  : per-requester pad enables (active low)
//   gnt_o       out N_REQ    : one-hot grant (registered)
//   owner_o     out IW       : current owner index, valid while busy_o
//   busy_o      out 1        : high in OWN and DRAIN
//   pad_in_i    in  W        : pad input bus
//   req_in_o    out W        : pad_in_i broadcast to requesters
//   pad_out_o   out W        : registered pad output values
//   pad_oeb_o   out W        : registered pad output enables (active low)
//   dbg_state_o out 2        : FSM state for observation
//
// Handshake: a requester holds req_i high for as long as it wants the bank;
// it owns the pads while its gnt_o bit is high and releases by dropping
// req_i. The grant falls at the edge that samples req_i low.
// ---------------------------------------------------------------------------
module io_pad_arbiter
  import io_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int W           = DEF_W,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*W-1:0]        req_out_i,
  input  logic [N_REQ*W-1:0]        req_oeb_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [idx_width(N_REQ)-1:0] owner_o,
  output logic                      busy_o,
  input  logic [W-1:0]              pad_in_i,
  output logic [W-1:0]              req_in_o,
  output logic [W-1:0]              pad_out_o,
  output logic [W-1:0]              pad_oeb_o,
  output logic [1:0]                dbg_state_o
);

  localparam int IW = idx_width(N_REQ);
  localparam int CW = 4;

  io_arb_state_t    r_state;
  io_arb_state_t    w_state_nxt;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_owner;
  logic [N_REQ-1:0] r_gnt;
  logic [CW-1:0]    r_dcnt;
  logic [W-1:0]     r_pad_out;
  logic [W-1:0]     r_pad_oeb;

  logic             w_valid;
  logic [N_REQ-1:0] w_win_oh;
  logic [IW-1:0]    w_win_idx;
  logic             w_release;
  logic             w_timeout;
  logic [W-1:0]     w_own_out;
  logic [W-1:0]     w_own_oeb;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req_i     (req_i),
    .ptr_i     (r_ptr),
    .valid_o   (w_valid),
    .win_oh_o  (w_win_oh),
    .win_idx_o (w_win_idx)
  );

  assign w_release = ~req_i[r_owner];
  assign w_own_out = req_out_i[int'(r_owner)*W +: W];
  assign w_own_oeb = req_oeb_i[int'(r_owner)*W +: W];

`ifdef IO_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;

  // Count holds at TIMEOUT-1 so a late-arriving competitor preempts at once.
  assign w_timeout = (r_state == OWN) && (r_tcnt == TW'(TIMEOUT - 1)) &&
                     (|(req_i & ~r_gnt));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || (r_state != OWN)) begin
      r_tcnt <= '0;
    end else if (r_tcnt != TW'(TIMEOUT - 1)) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_valid) w_state_nxt = OWN;
      OWN:     if (w_release || w_timeout) w_state_nxt = DRAIN;
      DRAIN:   if (r_dcnt <= CW'(1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_dcnt    <= '0;
      r_pad_out <= '0;
      r_pad_oeb <= '1;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_gnt   <= w_win_oh;
            r_owner <= w_win_idx;
            r_ptr   <= (w_win_idx == IW'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;
          end
        end
        OWN: begin
          if (w_state_nxt == DRAIN) begin
            r_gnt  <= '0;
            r_dcnt <= CW'(TURN_CYCLES);
          end
        end
        DRAIN: begin
          if (r_dcnt != '0) r_dcnt <= r_dcnt - 1'b1;
        end
        default: ;
      endcase
      // Pads follow the owner only while ownership continues; the grant
      // edge and the release edge both leave the pads tri-stated.
      if ((r_state == OWN) && (w_state_nxt == OWN)) begin
        r_pad_out <= w_own_out;
        r_pad_oeb <= w_own_oeb;
      end else begin
        r_pad_out <= '0;
        r_pad_oeb <= '1;
      end
    end
  end

  assign gnt_o       = r_gnt;
  assign owner_o     = r_owner;
  assign busy_o      = (r_state != IDLE);
  assign req_in_o    = pad_in_i;
  assign pad_out_o   = r_pad_out;
  assign pad_oeb_o   = r_pad_oeb;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_io_pad_arbiter.sv
module tb_io_pad_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TC = 2;
  localparam int TO = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req      = '0;
  logic [N*W-1:0] req_out  = '0;
  logic [N*W-1:0] req_oeb  = '1;
  logic [W-1:0]   pad_in   = '0;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic           busy;
  logic [W-1:0]   req_in;
  logic [W-1:0]   pad_out;
  logic [W-1:0]   pad_oeb;
  logic [1:0]     dbg_state;

  io_pad_arbiter #(
    .N_REQ(N), .W(W), .TURN_CYCLES(TC), .TIMEOUT(TO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .req_i      (req),
    .req_out_i  (req_out),
    .req_oeb_i  (req_oeb),
    .gnt_o      (gnt),
    .owner_o    (owner),
    .busy_o     (busy),
    .pad_in_i   (pad_in),
    .req_in_o   (req_in),
    .pad_out_o  (pad_out),
    .pad_oeb_o  (pad_oeb),
    .dbg_state_o(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slice `keep` carries base; every other slice carries noise.
  task automatic drive_slices(input int keep, input logic [W-1:0] base, input logic [W-1:0] noise);
    for (int k = 0; k < N; k++) begin
      req_out[k*W +: W] = (k == keep) ? base : noise;
      req_oeb[k*W +: W] = (k == keep) ? ~base : ~noise;
    end
  endtask

  typedef struct {
    logic           rst;
    logic [N-1:0]   req;
    int             keep;
    logic [W-1:0]   base;
    logic [W-1:0]   noise;
    logic [N-1:0]   exp_gnt;
    logic           exp_busy;
    logic [W-1:0]   exp_out;
    logic [W-1:0]   exp_oeb;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic r, logic [N-1:0] rq, int kp, logic [W-1:0] b, logic [W-1:0] nz,
                              logic [N-1:0] eg, logic eb, logic [W-1:0] eo, logic [W-1:0] ee);
    vec_t v;
    v.rst = r; v.req = rq; v.keep = kp; v.base = b; v.noise = nz;
    v.exp_gnt = eg; v.exp_busy = eb; v.exp_out = eo; v.exp_oeb = ee;
    return v;
  endfunction

  int order[5];
  int viol;
  int waited;
  logic [N-1:0] e_gnt;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset, first grant to 0, pad lag, non-owner noise ignored
    vecs[0]  = mk(1, 4'b0101, 0, 16'h0000, 16'h0000, 4'b0000, 0, 16'h0000, 16'hFFFF);
    vecs[1]  = mk(0, 4'b0101, 0, 16'h1234, 16'h0000, 4'b0001, 1, 16'h0000, 16'hFFFF);
    vecs[2]  = mk(0, 4'b0101, 0, 16'h1234, 16'h0000, 4'b0001, 1, 16'h1234, 16'hEDCB);
    vecs[3]  = mk(0, 4'b0101, 0, 16'h5678, 16'hFFFF, 4'b0001, 1, 16'h5678, 16'hA987);
    vecs[4]  = mk(0, 4'b0101, 0, 16'h9ABC, 16'h0000, 4'b0001, 1, 16'h9ABC, 16'h6543);
    // release with req 2 waiting: 2 drain cycles, 1 idle, then grant 2
    vecs[5]  = mk(0, 4'b0100, 0, 16'h0000, 16'hFFFF, 4'b0000, 1, 16'h0000, 16'hFFFF);
    vecs[6]  = mk(0, 4'b0100, 0, 16'h0000, 16'hFFFF, 4'b0000, 1, 16'h0000, 16'hFFFF);
    vecs[7]  = mk(0, 4'b0100, 0, 16'h0000, 16'hFFFF, 4'b0000, 0, 16'h0000, 16'hFFFF);
    vecs[8]  = mk(0, 4'b0100, 2, 16'h1111, 16'hFFFF, 4'b0100, 1, 16'h0000, 16'hFFFF);
    vecs[9]  = mk(0, 4'b0100, 2, 16'h1111, 16'hFFFF, 4'b0100, 1, 16'h1111, 16'hEEEE);
    // release; requests raised during drain wait; ptr=3 wraps to 0
    vecs[10] = mk(0, 4'b0000, 0, 16'h0000, 16'h0000, 4'b0000, 1, 16'h0000, 16'hFFFF);
    vecs[11] = mk(0, 4'b0011, 0, 16'h0000, 16'h0000, 4'b0000, 1, 16'h0000, 16'hFFFF);
    vecs[12] = mk(0, 4'b0011, 0, 16'h0000, 16'h0000, 4'b0000, 0, 16'h0000, 16'hFFFF);
    vecs[13] = mk(0, 4'b0011, 0, 16'h2222, 16'hFFFF, 4'b0001, 1, 16'h0000, 16'hFFFF);
    vecs[14] = mk(0, 4'b0011, 0, 16'h2222, 16'hFFFF, 4'b0001, 1, 16'h2222, 16'hDDDD);
    // reset mid-OWN: immediate drop, then requester 0 wins over 1
    vecs[15] = mk(1, 4'b0011, 0, 16'h2222, 16'h0000, 4'b0000, 0, 16'h0000, 16'hFFFF);
    vecs[16] = mk(0, 4'b0011, 0, 16'h2222, 16'h0000, 4'b0001, 1, 16'h0000, 16'hFFFF);
    vecs[17] = mk(0, 4'b0000, 0, 16'h0000, 16'h0000, 4'b0000, 1, 16'h0000, 16'hFFFF);
    vecs[18] = mk(0, 4'b0000, 0, 16'h0000, 16'h0000, 4'b0000, 1, 16'h0000, 16'hFFFF);
    vecs[19] = mk(0, 4'b0000, 0, 16'h0000, 16'h0000, 4'b0000, 0, 16'h0000, 16'hFFFF);
    vecs[20] = mk(0, 4'b0000, 0, 16'h0000, 16'h0000, 4'b0000, 0, 16'h0000, 16'hFFFF);

    for (int i = 0; i < 21; i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      drive_slices(vecs[i].keep, vecs[i].base, vecs[i].noise);
      pad_in = 16'(i * 16'h0101);
      step();
      check($sformatf("vec%0d_gnt", i),  32'(gnt),     32'(vecs[i].exp_gnt));
      check($sformatf("vec%0d_busy", i), 32'(busy),    32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_out", i),  32'(pad_out), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_oeb", i),  32'(pad_oeb), 32'(vecs[i].exp_oeb));
      check($sformatf("vec%0d_in", i),   32'(req_in),  32'(16'(i * 16'h0101)));
      if (i == 0) check("reset_state_idle", 32'(dbg_state), 32'd0);
    end

    // all four requesting: order 0,1,2,3,0 with a TC+1 gap between grants
    rst = 1'b1; req = '0; step(); rst = 1'b0;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    viol = 0;
    req = 4'b1111;
    drive_slices(0, 16'hCAFE, 16'h0F0F);
    for (int g = 0; g < 5; g++) begin
      waited = 0;
      while (gnt == '0 && waited < 12) begin
        step();
        waited++;
        if ($countones(gnt) > 1) viol++;
      end
      e_gnt = '0;
      e_gnt[order[g]] = 1'b1;
      check($sformatf("rr%0d_grant", g), 32'(gnt), 32'(e_gnt));
      check($sformatf("rr%0d_owner", g), 32'(owner), 32'(order[g]));
      if (g > 0) check($sformatf("rr%0d_gap", g), 32'(waited), 32'(TC + 1));
      repeat (4) begin
        step();
        if ($countones(gnt) > 1) viol++;
      end
      req[order[g]] = 1'b0;
      step();
      check($sformatf("rr%0d_release", g), 32'(gnt), 32'd0);
      req[order[g]] = 1'b1;
    end
    check("rr_onehot", 32'(viol), 32'd0);

`ifdef IO_ARB_TIMEOUT_EN
    // req 1 holds forever, req 3 arrives: preempted 8 cycles after grant
    rst = 1'b1; req = '0; step(); rst = 1'b0;
    req = 4'b0010;
    step();
    check("to_grant1", 32'(gnt), 32'h2);
    req = 4'b1010;
    for (int j = 1; j <= TO; j++) begin
      step();
      check($sformatf("to_hold%0d", j), 32'(gnt), (j < TO) ? 32'h2 : 32'h0);
    end
    repeat (TC + 1) step();
    check("to_grant3", 32'(gnt), 32'h8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
